box_painter: RTL and testbench
==============================

BOX_PAINTER -- requirements
Module: box_painter

Interface
REQ-001 Parameter BOX_SIZE, default 32, box edge length in pixels.
REQ-002 Parameter STEP, default 2, box displacement in pixels per frame.
REQ-003 Parameter X_INIT, default 304, box left edge after reset.
REQ-004 Parameter Y_INIT, default 224, box top edge after reset.
REQ-005 Parameter BLINK_FRAMES, default 30, frames between box colour toggles.
REQ-006 vgaclk  in  1  pixel clock, 25 MHz; all state SHALL update on its rising edge.
REQ-007 rst  in  1  synchronous, active-low reset.
REQ-008 hc  in  10  horizontal counter from VGA timing stage, 0..799.
REQ-009 vc  in  10  vertical counter from VGA timing stage, 0..524.
REQ-010 btn_up, btn_down, btn_left, btn_right  in  1 each  asynchronous push buttons, active-high.
REQ-011 mode_bounce  in  1  asynchronous switch; 1 = autonomous bounce, 0 = manual.
REQ-012 red, green, blue  out  4 each  pixel colour to VGA timing stage.
REQ-013 frame_tick  out  1  one-cycle frame-boundary strobe.
REQ-014 box_x, box_y  out  10 each  current box top-left position.

Function
REQ-015 frame_tick SHALL be 1 exactly when hc==0 and vc==480 (combinational decode), else 0.
REQ-016 Each button and mode_bounce SHALL pass through a two-flop synchronizer; only synchronized values are used.
REQ-017 box_x, box_y, direction and mode SHALL change only on the edge where frame_tick==1; no mid-frame update.
REQ-018 Manual mode: x += STEP if right&~left, x -= STEP if left&~right, else unchanged; same for y with down/up.
REQ-019 Arithmetic SHALL use at least 11-bit signed intermediates; results clamp to x in [0, 640-BOX_SIZE], y in [0, 480-BOX_SIZE].
REQ-020 Bounce mode: state registers dx, dy in {+1,-1}; x += dx*STEP, y += dy*STEP each frame; buttons ignored.
REQ-021 Bounce: if the next position reaches or passes a bound, position SHALL clamp to that bound and that axis direction SHALL invert in the same update.
REQ-022 Both axes hitting bounds in one frame (corner) SHALL clamp and invert both.
REQ-023 Mode change SHALL take effect at the next frame_tick; dx, dy SHALL retain values across manual periods.
REQ-024 Frame counter SHALL increment on each frame_tick, wrap to 0 upon reaching BLINK_FRAMES-1, and toggle blink bit on that wrap.
REQ-025 Colour SHALL be combinational from hc, vc and registered state (zero latency), priority order:
  - hc>=640 or vc>=480: 0,0,0
  - box: box_x<=hc<box_x+BOX_SIZE and box_y<=vc<box_y+BOX_SIZE: blink=0 -> F,F,F; blink=1 -> F,F,0
  - border: hc<4, hc>=636, vc<4 or vc>=476: 0,0,F
  - background: 2,2,2
REQ-026 box_x, box_y outputs SHALL equal the position registers directly.

Reset
REQ-027 With rst==0 at a rising edge: box_x=X_INIT, box_y=Y_INIT, dx=+1, dy=+1, frame counter 0, blink 0, synchronizer flops 0, mode manual.
REQ-028 Reset SHALL take priority over a coincident frame_tick; colour and frame_tick outputs remain decoded from hc/vc during reset.
REQ-029 Reset asserted mid-frame SHALL restore reset values on that edge; the first move occurs at the first frame_tick after rst returns high.

Verification
REQ-030 Reset, no buttons, 3 frames -> box_x=304, box_y=224; pixel (hc=304,vc=224)=F,F,F; (303,224)=2,2,2; (0,0)=0,0,F; (700,100)=0,0,0.
REQ-031 btn_right held 5 frames, then btn_left+btn_right held 2 frames -> box_x=314 after the 5th tick, unchanged at 314 after 2 more.
REQ-032 Manual, box_x=0, btn_left held 3 frames -> box_x stays 0; box_y=447, btn_down held -> box_y clamps to 448.
REQ-033 Bounce mode from box_x=606, dx=+1 -> next tick box_x=608, dx=-1; following tick box_x=606; corner (608,448) inverts both directions.
REQ-034 Run 30 frames -> blink=1, box colour F,F,0 at (box_x,box_y); 60 frames -> F,F,F again.
REQ-035 Assert rst at hc=100, vc=200 after moves -> next edge box_x=304, box_y=224, frame counter 0; frame_tick at (0,480) during reset causes no move.

Source files
------------

// File: rtl/box_painter.sv
// rtl/box_painter.sv - moving/bouncing box overlay for a 640x480 VGA pixel stream
`timescale 1ns/1ps
module box_painter #(
    parameter int BOX_SIZE     = 32,
    parameter int STEP         = 2,
    parameter int X_INIT       = 304,
    parameter int Y_INIT       = 224,
    parameter int BLINK_FRAMES = 30
) (
    input  logic       vgaclk,
    input  logic       rst,
    input  logic [9:0] hc,
    input  logic [9:0] vc,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       mode_bounce,
    output logic [3:0] red,
    output logic [3:0] green,
    output logic [3:0] blue,
    output logic       frame_tick,
    output logic [9:0] box_x,
    output logic [9:0] box_y
);
    localparam logic signed [11:0] X_MAX  = 12'(640 - BOX_SIZE);
    localparam logic signed [11:0] Y_MAX  = 12'(480 - BOX_SIZE);
    localparam logic signed [11:0] STEP_S = 12'(STEP);
    localparam int CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    // Synchronizer bit order: {mode, right, left, down, up}
    logic [4:0] sync1_q, sync2_q;
    logic       up_s, down_s, left_s, right_s, bounce_s;

    logic [9:0]    x_q, x_d, y_q, y_d;
    logic          dxn_q, dxn_d, dyn_q, dyn_d;   // 1 means moving towards 0
    logic [CW-1:0] cnt_q, cnt_d;
    logic          blink_q, blink_d;

    logic [10:0] x_end, y_end;
    logic        in_box, on_border, off_screen;

    assign frame_tick = (hc == 10'd0) && (vc == 10'd480);
    assign {bounce_s, right_s, left_s, down_s, up_s} = sync2_q;
    assign box_x = x_q;
    assign box_y = y_q;

    // One axis of motion: returns {new_dir_neg, new_pos}, clamped to [0, max_v].
    // In bounce mode reaching or crossing a bound flips the direction.
    function automatic logic [10:0] step_axis(
        input logic [9:0]          pos,
        input logic                dir_neg,
        input logic                inc,
        input logic                dec,
        input logic                bounce,
        input logic signed [11:0]  max_v
    );
        logic signed [11:0] p;
        logic signed [11:0] n;
        logic               nd;
        p  = $signed({2'b00, pos});
        nd = dir_neg;
        if (bounce)
            n = dir_neg ? (p - STEP_S) : (p + STEP_S);
        else if (inc && !dec)
            n = p + STEP_S;
        else if (dec && !inc)
            n = p - STEP_S;
        else
            n = p;
        if (n >= max_v) begin
            n = max_v;
            if (bounce) nd = 1'b1;
        end else if (n <= 12'sd0) begin
            n = 12'sd0;
            if (bounce) nd = 1'b0;
        end
        return {nd, n[9:0]};
    endfunction

    // Two-flop synchronizers for the asynchronous buttons and mode switch
    always_ff @(posedge vgaclk) begin
        if (!rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {mode_bounce, btn_right, btn_left, btn_down, btn_up};
            sync2_q <= sync1_q;
        end
    end

    // Next position, direction and blink state, applied only at the frame boundary
    always_comb begin
        {dxn_d, x_d} = step_axis(x_q, dxn_q, right_s, left_s, bounce_s, X_MAX);
        {dyn_d, y_d} = step_axis(y_q, dyn_q, down_s, up_s, bounce_s, Y_MAX);
        cnt_d   = cnt_q + CW'(1);
        blink_d = blink_q;
        if (cnt_q == CW'(BLINK_FRAMES - 1)) begin
            cnt_d   = '0;
            blink_d = ~blink_q;
        end
    end

    // Frame-rate state: reset wins over a coincident frame_tick
    always_ff @(posedge vgaclk) begin
        if (!rst) begin
            x_q     <= 10'(X_INIT);
            y_q     <= 10'(Y_INIT);
            dxn_q   <= 1'b0;
            dyn_q   <= 1'b0;
            cnt_q   <= '0;
            blink_q <= 1'b0;
        end else if (frame_tick) begin
            x_q     <= x_d;
            y_q     <= y_d;
            dxn_q   <= dxn_d;
            dyn_q   <= dyn_d;
            cnt_q   <= cnt_d;
            blink_q <= blink_d;
        end
    end

    assign x_end      = {1'b0, x_q} + 11'(BOX_SIZE);
    assign y_end      = {1'b0, y_q} + 11'(BOX_SIZE);
    assign off_screen = (hc >= 10'd640) || (vc >= 10'd480);
    assign in_box     = (hc >= x_q) && ({1'b0, hc} < x_end) &&
                        (vc >= y_q) && ({1'b0, vc} < y_end);
    assign on_border  = (hc < 10'd4) || (hc >= 10'd636) || (vc < 10'd4) || (vc >= 10'd476);

    // Zero-latency pixel colour: blanking, box, border, background
    always_comb begin
        {red, green, blue} = 12'h222;
        if (off_screen)
            {red, green, blue} = 12'h000;
        else if (in_box)
            {red, green, blue} = blink_q ? 12'hFF0 : 12'hFFF;
        else if (on_border)
            {red, green, blue} = 12'h00F;
    end
endmodule

// File: tb/tb_box_painter.sv
// tb/tb_box_painter.sv - scoreboard bench for box_painter
`timescale 1ns/1ps
module tb_box_painter;
    logic       vgaclk = 1'b0;
    logic       rst;
    logic [9:0] hc, vc;
    logic       btn_up, btn_down, btn_left, btn_right, mode_bounce;
    logic [3:0] red, green, blue;
    logic       frame_tick;
    logic [9:0] box_x, box_y;

    typedef struct {
        string      name;
        logic [9:0] x;
        logic [9:0] y;
        logic [11:0] rgb;
        logic       chk_rgb;
        logic       tick;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    logic probe_valid = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #20 vgaclk = ~vgaclk;

    box_painter dut (
        .vgaclk      (vgaclk),
        .rst         (rst),
        .hc          (hc),
        .vc          (vc),
        .btn_up      (btn_up),
        .btn_down    (btn_down),
        .btn_left    (btn_left),
        .btn_right   (btn_right),
        .mode_bounce (mode_bounce),
        .red         (red),
        .green       (green),
        .blue        (blue),
        .frame_tick  (frame_tick),
        .box_x       (box_x),
        .box_y       (box_y)
    );

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    // Monitor: pops one expectation per presented probe cycle
    always @(negedge vgaclk) begin
        if (probe_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL scoreboard_empty: got no entry expected one");
            end else begin
                mon_e = exp_q.pop_front();
                chk({mon_e.name, "_x"}, {6'd0, box_x}, {6'd0, mon_e.x});
                chk({mon_e.name, "_y"}, {6'd0, box_y}, {6'd0, mon_e.y});
                chk({mon_e.name, "_tick"}, {15'd0, frame_tick}, {15'd0, mon_e.tick});
                if (mon_e.chk_rgb)
                    chk({mon_e.name, "_rgb"}, {4'd0, red, green, blue}, {4'd0, mon_e.rgb});
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge vgaclk); #1;
            hc = 10'd10;
            vc = 10'd10;
        end
    endtask

    task automatic frames(input int n);
        repeat (n) begin
            idle(2);
            @(posedge vgaclk); #1;
            hc = 10'd0;
            vc = 10'd480;
            @(posedge vgaclk); #1;
            hc = 10'd10;
            vc = 10'd10;
        end
    endtask

    task automatic probe(input string nm, input int h, input int v, input int ex, input int ey,
                         input logic [11:0] rgb, input logic crgb, input logic tk);
        exp_t e;
        @(posedge vgaclk); #1;
        hc = 10'(h);
        vc = 10'(v);
        e.name = nm; e.x = 10'(ex); e.y = 10'(ey);
        e.rgb = rgb; e.chk_rgb = crgb; e.tick = tk;
        exp_q.push_back(e);
        probe_valid = 1'b1;
        @(posedge vgaclk); #1;
        probe_valid = 1'b0;
        hc = 10'd10;
        vc = 10'd10;
    endtask

    task automatic do_reset();
        {btn_up, btn_down, btn_left, btn_right, mode_bounce} = '0;
        rst = 1'b0;
        idle(2);
        rst = 1'b1;
        idle(1);
    endtask

    initial begin
        #10ms;
        n_cmp++;
        n_err++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        rst = 1'b0;
        hc = 10'd10;
        vc = 10'd10;
        {btn_up, btn_down, btn_left, btn_right, mode_bounce} = '0;

        // Reset state and static picture
        do_reset();
        probe("rst_pos", 304, 224, 304, 224, 12'hFFF, 1'b1, 1'b0);
        frames(3);
        probe("idle_box", 304, 224, 304, 224, 12'hFFF, 1'b1, 1'b0);
        probe("bg_left", 303, 224, 304, 224, 12'h222, 1'b1, 1'b0);
        probe("border00", 0, 0, 304, 224, 12'h00F, 1'b1, 1'b0);
        probe("blank", 700, 100, 304, 224, 12'h000, 1'b1, 1'b0);
        probe("border_r", 636, 100, 304, 224, 12'h00F, 1'b1, 1'b0);
        probe("box_last", 335, 255, 304, 224, 12'hFFF, 1'b1, 1'b0);
        probe("box_past", 336, 224, 304, 224, 12'h222, 1'b1, 1'b0);

        // Manual right, then both left+right cancel
        btn_right = 1'b1;
        frames(5);
        probe("right5", 10, 10, 314, 224, 12'h000, 1'b0, 1'b0);
        btn_left = 1'b1;
        frames(2);
        probe("lr_cancel", 10, 10, 314, 224, 12'h000, 1'b0, 1'b0);

        // Clamp at left and bottom bounds
        do_reset();
        btn_left = 1'b1;
        frames(152);
        probe("left_to0", 10, 10, 0, 224, 12'h000, 1'b0, 1'b0);
        frames(3);
        probe("left_clamp", 10, 10, 0, 224, 12'h000, 1'b0, 1'b0);
        btn_left = 1'b0;
        btn_down = 1'b1;
        frames(111);
        probe("down446", 10, 10, 0, 446, 12'h000, 1'b0, 1'b0);
        frames(1);
        probe("down448", 10, 10, 0, 448, 12'h000, 1'b0, 1'b0);
        frames(2);
        probe("down_clamp", 10, 10, 0, 448, 12'h000, 1'b0, 1'b0);
        btn_down = 1'b0;

        // Bounce into the corner, direction retention across manual
        do_reset();
        btn_right = 1'b1;
        frames(151);
        btn_right = 1'b0;
        btn_down = 1'b1;
        frames(111);
        btn_down = 1'b0;
        probe("pre_bounce", 10, 10, 606, 446, 12'h000, 1'b0, 1'b0);
        mode_bounce = 1'b1;
        frames(1);
        probe("corner", 10, 10, 608, 448, 12'h000, 1'b0, 1'b0);
        frames(1);
        probe("rebound1", 10, 10, 606, 446, 12'h000, 1'b0, 1'b0);
        frames(1);
        probe("rebound2", 10, 10, 604, 444, 12'h000, 1'b0, 1'b0);
        mode_bounce = 1'b0;
        frames(2);
        probe("manual_hold", 10, 10, 604, 444, 12'h000, 1'b0, 1'b0);
        mode_bounce = 1'b1;
        frames(1);
        probe("dir_kept", 10, 10, 602, 442, 12'h000, 1'b0, 1'b0);
        mode_bounce = 1'b0;

        // Blink timing
        do_reset();
        frames(29);
        probe("blink29", 304, 224, 304, 224, 12'hFFF, 1'b1, 1'b0);
        frames(1);
        probe("blink30", 304, 224, 304, 224, 12'hFF0, 1'b1, 1'b0);
        frames(29);
        probe("blink59", 304, 224, 304, 224, 12'hFF0, 1'b1, 1'b0);
        frames(1);
        probe("blink60", 304, 224, 304, 224, 12'hFFF, 1'b1, 1'b0);

        // Mid-frame reset after moves, frame_tick during reset
        do_reset();
        btn_right = 1'b1;
        frames(3);
        btn_right = 1'b0;
        frames(7);
        probe("pre_rst", 10, 10, 310, 224, 12'h000, 1'b0, 1'b0);
        @(posedge vgaclk); #1;
        hc = 10'd100;
        vc = 10'd200;
        rst = 1'b0;
        probe("mid_rst", 10, 10, 304, 224, 12'h000, 1'b0, 1'b0);
        probe("rst_tick", 0, 480, 304, 224, 12'h000, 1'b1, 1'b1);
        probe("rst_border", 0, 0, 304, 224, 12'h00F, 1'b1, 1'b0);
        rst = 1'b1;
        btn_right = 1'b1;
        frames(1);
        btn_right = 1'b0;
        probe("first_move", 10, 10, 306, 224, 12'h000, 1'b0, 1'b0);
        frames(28);
        probe("cnt_clr29", 306, 224, 306, 224, 12'hFFF, 1'b1, 1'b0);
        frames(1);
        probe("cnt_clr30", 306, 224, 306, 224, 12'hFF0, 1'b1, 1'b0);

        idle(4);
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
